// File: rtl/neural_pio_bank.sv
// neural_pio_bank: Avalon-MM GPIO bank with input synchroniser, per-bit
// debounce, sticky edge capture, maskable interrupt and atomic set/clear.
// Ports:
//   clk_clk, reset_reset  : clock, async active-high reset
//   avs_address/read/write/writedata -> avs_readdata : slave bus, read latency 1
//   pio_in_export         : raw board inputs (IN_WIDTH)
//   pio_out_export        : output register (OUT_WIDTH)
//   irq                   : level interrupt, OR of (capture & mask)
module neural_pio_bank #(
    parameter int IN_WIDTH        = 12,
    parameter int OUT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 2
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    input  logic [IN_WIDTH-1:0]  pio_in_export,
    output logic [OUT_WIDTH-1:0] pio_out_export,
    output logic                 irq
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] A_DIN  = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_CAP  = 3'd2;
    localparam logic [2:0] A_OUT  = 3'd3;
    localparam logic [2:0] A_SET  = 3'd4;
    localparam logic [2:0] A_CLR  = 3'd5;
    localparam logic [2:0] A_INFO = 3'd6;

    localparam logic [31:0] INFO = {8'h00, 8'(EDGE_MODE), 8'(IN_WIDTH), 8'(OUT_WIDTH)};

    logic [IN_WIDTH-1:0]  sync1;
    logic [IN_WIDTH-1:0]  sync2;
    logic [IN_WIDTH-1:0]  stable;
    logic [IN_WIDTH-1:0]  stable_d;
    logic [CNT_W-1:0]     cnt [IN_WIDTH];
    logic [IN_WIDTH-1:0]  mask;
    logic [IN_WIDTH-1:0]  cap;
    logic [IN_WIDTH-1:0]  rise;
    logic [IN_WIDTH-1:0]  fall;
    logic [IN_WIDTH-1:0]  edge_hit;
    logic [IN_WIDTH-1:0]  w1c;
    logic [OUT_WIDTH-1:0] dout;
    logic [31:0]          rd_data;
    logic                 wr_mask;
    logic                 wr_cap;
    logic                 wr_out;
    logic                 wr_set;
    logic                 wr_clr;
    logic                 wdata_unused;

    // Upper write-data bits beyond the register widths are don't-care.
    assign wdata_unused = ^avs_writedata;

    assign wr_mask = avs_write && (avs_address == A_MASK);
    assign wr_cap  = avs_write && (avs_address == A_CAP);
    assign wr_out  = avs_write && (avs_address == A_OUT);
    assign wr_set  = avs_write && (avs_address == A_SET);
    assign wr_clr  = avs_write && (avs_address == A_CLR);

    assign w1c = wr_cap ? avs_writedata[IN_WIDTH-1:0] : '0;

    // stable_d lags stable by one cycle, so an edge is seen the cycle after
    // the debounced value moves and lands in cap on the following edge.
    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    always_comb begin
        edge_hit = rise | fall;
        if (EDGE_MODE == 0) begin
            edge_hit = rise;
        end else if (EDGE_MODE == 1) begin
            edge_hit = fall;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pio_in_export;
            sync2 <= sync1;
        end
    end

    // The counter only runs while the synced bit disagrees with the stable
    // bit; any agreement restarts it, which rejects short glitches.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stable <= '0;
            for (int i = 0; i < IN_WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stable_d <= '0;
            mask     <= '0;
            cap      <= '0;
            irq      <= 1'b0;
            dout     <= '0;
        end else begin
            stable_d <= stable;
            if (wr_mask) begin
                mask <= avs_writedata[IN_WIDTH-1:0];
            end
            // New edges are OR-ed after the clear so set wins a collision.
            cap <= (cap & ~w1c) | edge_hit;
            irq <= |(cap & mask);
            if (wr_out) begin
                dout <= avs_writedata[OUT_WIDTH-1:0];
            end else if (wr_set) begin
                dout <= dout | avs_writedata[OUT_WIDTH-1:0];
            end else if (wr_clr) begin
                dout <= dout & ~avs_writedata[OUT_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (avs_address)
            A_DIN:   rd_data = 32'(stable);
            A_MASK:  rd_data = 32'(mask);
            A_CAP:   rd_data = 32'(cap);
            A_OUT:   rd_data = 32'(dout);
            A_INFO:  rd_data = INFO;
            default: rd_data = '0;
        endcase
    end

    // Read data comes from pre-edge state, so a same-cycle write is not
    // visible to the read that accompanies it.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_data;
        end
    end

    assign pio_out_export = dout;

endmodule

// File: tb/tb_neural_pio_bank.sv
// tb_neural_pio_bank: scoreboard bench for neural_pio_bank with a
// sample-history reference model; reads are queued and checked by a monitor.
module tb_neural_pio_bank;
    localparam int IW = 12;
    localparam int OW = 8;
    localparam int D  = 4;
    localparam int EM = 2;
    localparam logic [31:0] INFO_EXP = {8'h00, 8'(EM), 8'(IW), 8'(OW)};

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    avs_address;
    logic          avs_read;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [31:0]   avs_readdata;
    logic [IW-1:0] pin;
    logic [OW-1:0] pout;
    logic          irq;

    always #5 clk = ~clk;

    neural_pio_bank #(
        .IN_WIDTH(IW),
        .OUT_WIDTH(OW),
        .DEBOUNCE_CYCLES(D),
        .EDGE_MODE(EM)
    ) dut (
        .clk_clk(clk),
        .reset_reset(reset),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .pio_in_export(pin),
        .pio_out_export(pout),
        .irq(irq)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: hist[j] is the pin sample taken j+1 edges ago.
    // A bit settles to v once the D samples that have cleared the
    // two-stage synchroniser all equal v.
    logic [IW-1:0] hist [D+1];
    logic [IW-1:0] m_stable;
    logic [IW-1:0] m_stable_prev;
    logic [IW-1:0] m_mask;
    logic [IW-1:0] m_cap;
    logic [OW-1:0] m_dout;
    logic          m_irq;
    logic          m_rd_flag;
    logic [31:0]   exp_q [$];
    logic [31:0]   last_rd;

    function automatic logic [IW-1:0] settled(input logic [IW-1:0] cur);
        logic [IW-1:0] all1 = '1;
        logic [IW-1:0] any1 = '0;
        for (int j = 1; j <= D; j++) begin
            all1 &= hist[j];
            any1 |= hist[j];
        end
        return (cur | all1) & any1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_stable);
            3'd1:    return 32'(m_mask);
            3'd2:    return 32'(m_cap);
            3'd3:    return 32'(m_dout);
            3'd6:    return INFO_EXP;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j <= D; j++) hist[j] <= '0;
            m_stable      <= '0;
            m_stable_prev <= '0;
            m_mask        <= '0;
            m_cap         <= '0;
            m_dout        <= '0;
            m_irq         <= 1'b0;
            m_rd_flag     <= 1'b0;
            exp_q.delete();
        end else begin
            for (int j = D; j > 0; j--) hist[j] <= hist[j-1];
            hist[0]       <= pin;
            m_stable      <= settled(m_stable);
            m_stable_prev <= m_stable;
            m_irq         <= |(m_cap & m_mask);
            m_cap <= (m_cap & ~((avs_write && avs_address == 3'd2)
                                ? avs_writedata[IW-1:0] : '0))
                     | (m_stable ^ m_stable_prev);
            m_rd_flag <= avs_read;
            if (avs_read) exp_q.push_back(m_read(avs_address));
            if (avs_write) begin
                case (avs_address)
                    3'd1: m_mask <= avs_writedata[IW-1:0];
                    3'd3: m_dout <= avs_writedata[OW-1:0];
                    3'd4: m_dout <= m_dout | avs_writedata[OW-1:0];
                    3'd5: m_dout <= m_dout & ~avs_writedata[OW-1:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_cycle();
        logic [31:0] w;
        if (reset) last_rd = 32'h0;
        if (m_rd_flag) begin
            if (exp_q.size() == 0) begin
                check("read_underflow", 32'd1, 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("read", avs_readdata, w);
                last_rd = w;
            end
        end else begin
            check("rd_hold", avs_readdata, last_rd);
        end
        check("pio_out", 32'(pout), 32'(m_dout));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    always @(negedge clk) mon_cycle();

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic bus(input logic r, input logic w, input logic [2:0] a,
                       input logic [31:0] d);
        avs_read      = r;
        avs_write     = w;
        avs_address   = a;
        avs_writedata = d;
        step();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    initial begin
        last_rd       = 32'h0;
        reset         = 1'b1;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_address   = 3'd0;
        avs_writedata = 32'h0;
        pin           = '1;
        repeat (3) step();
        check("rst_rdata", avs_readdata, 32'h0);
        check("rst_pout", 32'(pout), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        // Inputs held high through reset debounce in after release.
        reset = 1'b0;
        repeat (6) step();
        bus(1'b1, 1'b0, 3'd0, 32'h0);
        check("boot_din", avs_readdata, 32'h0000_0FFF);

        pin = '0;
        repeat (10) step();
        bus(1'b0, 1'b1, 3'd2, 32'hFFF);
        repeat (2) step();

        // Glitch of D-1 cycles.
        pin[0] = 1'b1;
        repeat (3) step();
        pin[0] = 1'b0;
        for (int i = 0; i < 10; i++) bus(1'b1, 1'b0, 3'(i % 3 == 0 ? 2 : 0), 32'h0);
        check("glitch_cap", avs_readdata, 32'h0);

        // Clean step: visible to a read sampled on edge 7, not edge 6.
        pin[0] = 1'b1;
        repeat (5) step();
        bus(1'b1, 1'b0, 3'd0, 32'h0);
        check("lat_edge6", avs_readdata & 32'h1, 32'h0);
        bus(1'b1, 1'b0, 3'd0, 32'h0);
        check("lat_edge7", avs_readdata & 32'h1, 32'h1);

        // Mask bit0 with the rising edge already captured, then clear.
        bus(1'b0, 1'b1, 3'd1, 32'h1);
        repeat (3) step();
        check("irq_on", 32'(irq), 32'h1);
        bus(1'b0, 1'b1, 3'd2, 32'h1);
        step();
        check("irq_off", 32'(irq), 32'h0);
        pin[0] = 1'b0;
        for (int i = 0; i < 10; i++) bus(1'b1, 1'b0, 3'd2, 32'h0);
        check("fall_cap", avs_readdata & 32'h1, 32'h1);

        // W1C lands on the same edge as a new capture.
        pin[0] = 1'b1;
        repeat (6) step();
        bus(1'b0, 1'b1, 3'd2, 32'h1);
        step();
        bus(1'b1, 1'b0, 3'd2, 32'h0);
        check("set_wins", avs_readdata & 32'h1, 32'h1);
        check("set_wins_irq", 32'(irq), 32'h1);

        // Output register and atomic set/clear.
        bus(1'b0, 1'b1, 3'd3, 32'hA5);
        check("out_a5", 32'(pout), 32'hA5);
        bus(1'b0, 1'b1, 3'd4, 32'h0F);
        check("out_af", 32'(pout), 32'hAF);
        bus(1'b0, 1'b1, 3'd5, 32'h81);
        check("out_2e", 32'(pout), 32'h2E);
        bus(1'b1, 1'b0, 3'd3, 32'h0);
        bus(1'b1, 1'b0, 3'd4, 32'h0);
        check("set_reads0", avs_readdata, 32'h0);

        // Same-cycle read and write returns the old value.
        bus(1'b0, 1'b1, 3'd1, 32'h0);
        bus(1'b1, 1'b1, 3'd1, 32'h3);
        check("collide_old", avs_readdata, 32'h0);
        bus(1'b1, 1'b0, 3'd1, 32'h0);
        check("collide_new", avs_readdata, 32'h3);
        bus(1'b1, 1'b0, 3'd6, 32'h0);
        check("info", avs_readdata, 32'h0002_0C08);

        // Randomised traffic with one reset in the middle.
        for (int n = 0; n < 1600; n++) begin
            if (n == 800) begin
                pin   = '1;
                reset = 1'b1;
                repeat (2) step();
                reset = 1'b0;
            end
            if ($urandom_range(5) == 0) pin = IW'($urandom);
            else if ($urandom_range(9) == 0) pin[$urandom_range(IW-1)] ^= 1'b1;
            bus(1'($urandom_range(1)), ($urandom_range(2) == 0),
                3'($urandom_range(7)), $urandom);
        end

        repeat (3) step();
        check("q_drain", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neural_pio_bank.md
Name: neural_pio_bank

Overview:
- Parametrised Avalon-MM slave general-purpose I/O bank.
- Replaces the fixed key (4-bit), switch (8-bit) and LED (8-bit) PIOs in the neural SoC with one configurable block.
- Adds per-bit input synchronisation and debounce, sticky edge capture with a maskable interrupt, and atomic set/clear of output bits.
- Sits on the SoC data-master bus alongside SDRAM; drives board LEDs and samples keys/switches.

Parameters:
- IN_WIDTH, 12, number of input channels, 1..32 (keys in the low bits, switches above).
- OUT_WIDTH, 8, number of output channels, 1..32.
- DEBOUNCE_CYCLES, 50000, stable cycles required before an input change is accepted, ≥1.
- EDGE_MODE, 2, edge type captured: 0 rising, 1 falling, 2 both.
- Derived localparam CNT_W = clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  reset; asynchronous, active-high.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, registered.
- pio_in_export  in  IN_WIDTH  raw asynchronous board inputs.
- pio_out_export  out  OUT_WIDTH  output register.
- irq  out  1  level interrupt.

Behaviour:
- One clock domain; asynchronous, active-high reset.
- Reset values:
  - avs_readdata = 0, pio_out_export = 0, irq = 0.
  - Sync flops = 0, debounced state = 0, counters = 0, mask = 0, edge capture = 0.
- Input path, per bit:
  - Two-flop synchroniser feeds the debounce stage.
  - Debounce: if the synced value differs from the stable value, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable value.
  - Latency: a clean input step appears in the stable value 2+DEBOUNCE_CYCLES cycles after the pin changes.
- Edge capture:
  - Edge = stable value changed this cycle, filtered by EDGE_MODE.
  - A qualifying edge sets the capture bit the following cycle.
  - Capture bits are sticky until cleared by a 1 written to register 2.
  - Same cycle, same bit, W1C and new edge: the bit stays set (set wins).
- irq:
  - Registered OR of (capture & mask).
  - Asserts one cycle after the capture or mask bit becomes 1.
  - Deasserts one cycle after clear or unmask.
- Register map (unused upper bits read 0, writes to them ignored):
  - 0 DATA_IN, RO: debounced stable inputs.
  - 1 IRQ_MASK, RW: IN_WIDTH bits.
  - 2 EDGE_CAP: read gives capture bits; write 1 to a bit clears it.
  - 3 DATA_OUT, RW: drives pio_out_export directly.
  - 4 OUT_SET, WO: 1 bits set DATA_OUT bits; reads 0.
  - 5 OUT_CLR, WO: 1 bits clear DATA_OUT bits; reads 0.
  - 6 INFO, RO: {8'h0, EDGE_MODE[7:0], IN_WIDTH[7:0], OUT_WIDTH[7:0]}.
  - 7 reserved: reads 0, writes ignored.
- Bus timing:
  - Fixed read latency 1: avs_readdata is valid the cycle after avs_read and holds until the next read.
  - Writes take effect at the clock edge of avs_write; pio_out_export changes that edge.
  - avs_read and avs_write in the same cycle: the write commits; the read returns the pre-write value.
  - No waitrequest; back-to-back accesses are supported every cycle.
- Reset mid-debounce or mid-access: all state returns to reset values immediately. An input held high through reset is re-debounced from 0 and produces a rising edge after release.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4: hold reset_reset with pio_in=12'hFFF -> readdata 0, pio_out 0, irq 0. Release, wait 7 cycles, read addr0 -> 12'hFFF.
- Glitch reject: pulse in[0] high 3 cycles -> addr0 bit0 stays 0, EDGE_CAP 0. Hold 4+ cycles -> bit0 = 1 exactly 6 cycles after the pin edge.
- Edge/irq, EDGE_MODE=2, mask=1: toggle in[0] 0->1->0 debounced -> EDGE_CAP=1, irq high one cycle after capture. Write 1 to addr2 -> irq low next cycle. Falling edge re-sets the bit.
- Set-wins: schedule a W1C of bit0 in the same cycle a new bit0 edge is captured -> EDGE_CAP bit0 remains 1, irq stays 1.
- Outputs: write addr3=8'hA5, then addr4=8'h0F, then addr5=8'h81 -> pio_out A5, AF, 2E; read addr3 -> 2E, addr4 -> 0.
- Read/write collision: read and write addr1=32'h3 in the same cycle with prior value 0 -> readdata 0, next read -> 3. Read addr6 -> 32'h00020C08.
